sprite_compositor: RTL and testbench
====================================

Name: sprite_compositor

Overview:
- Parametrised, pipelined successor to the tank/bullet colour mapper.
- Composites N_TANKS tank sprites (base and turret, 8 directions each), N_TANKS×N_BULLETS round bullets, and a tiled background into 24-bit RGB for the VGA path.
- Adds four things:
  - Frame-latched object state, so there is no mid-frame tearing.
  - An external synchronous sprite/background ROM interface with fixed latency.
  - Per-tank hit-flash timers.
  - Fall-through transparency, so tank → bullet → background.

Parameters:
- N_TANKS, 2, number of tanks; index 0 has the highest priority.
- N_BULLETS, 8, bullet slots per tank.
- SPR_LOG2, 5, log2 of the sprite and background-tile edge (32 px).
- BALL_SIZE, 4, bullet radius in pixels.
- FLASH_FRAMES, 16, frames a tank flashes after a hit.

Ports:
- CLK  in  1  pixel-rate clock; all logic is on its rising edge.
- Reset  in  1  synchronous, active-high.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- DrawX, DrawY  in  10 each  current pixel coordinates.
- blank  in  1  1 = active video (same polarity as the VGA controller).
- tank_active  in  N_TANKS  per-tank draw enable.
- tank_x, tank_y  in  [N_TANKS][10]  tank top-left corner.
- base_dir, turret_dir  in  [N_TANKS][3]  sprite direction index.
- bullet_array  in  [N_TANKS][N_BULLETS][32]  bit0 = valid, [18:9] = x centre, [28:19] = y centre.
- hit_pulse  in  N_TANKS  one-cycle pulse: tank was hit.
- spr_addr  out  3+2*SPR_LOG2  {dir, local_y, local_x}; fed to the base and turret ROMs (separate dir fields below).
- base_dir_q, turret_dir_q  out  3 each  ROM bank selects.
- base_rgb, turret_rgb  in  24 each  ROM data, one cycle after the address.
- bg_addr  out  2*SPR_LOG2  {DrawY mod 32, DrawX mod 32}.
- bg_rgb  in  24  background ROM data, one cycle after the address.
- Red, Green, Blue  out  8 each  composited pixel.

Behaviour:
- Shadow state:
  - tank_active, tank_x, tank_y, directions and bullet_array are copied into shadow registers only on the cycle frame_start = 1.
  - All compositing uses shadow values only.
  - Reset clears shadow tank_active and every shadow bullet valid bit, so nothing but background is drawn until the first frame_start.
- Pipeline: latency is exactly 3 cycles from DrawX/DrawY/blank to Red/Green/Blue.
- S0 (cycle t):
  - Tank hit: DrawX in [x, x+32) and DrawY in [y, y+32), using 11-bit compares (no wrap at 1023).
  - Select the lowest-index active hitting tank; register its index, spr_addr, dir selects and bg_addr.
  - Bullet hit: signed 11-bit dx, dy; dx²+dy² ≤ BALL_SIZE²; valid bit required. Select the lowest flat index (tank*N_BULLETS + slot); register the owner index and a hit flag.
- S1 (t+1): addresses present at the ROMs; pass sideband (blank, hit flags, indices) through.
- S2 (t+2): ROM data valid. Composite the first non-transparent source, with 24'h000000 as the transparent key:
  1. turret_rgb
  2. base_rgb (only if a tank hit)
  3. bullet colour BULLET_PAL[owner] (if a bullet hit)
  4. bg_rgb
- Flash: if the selected tank's flash_cnt ≠ 0 and flash_cnt[1] = 1, opaque tank pixels become 24'hFFFFFF.
- Blank: blank = 0 at S2 forces output 0. Red/Green/Blue are registered at t+3 and reset to 0.
- Flash counters:
  - hit_pulse[i] loads FLASH_FRAMES.
  - frame_start decrements a nonzero counter; a zero counter saturates at 0.
  - hit_pulse and frame_start in the same cycle: the load wins.
  - Reset clears all counters.
- Inputs changing mid-frame have no visible effect until the next frame_start.
- A Reset asserted mid-line flushes the pipeline; outputs are 0 for the 3 following cycles.

Optional Feature:
- BBOX_DEBUG_EN defined:
  - Any pixel on the 1-px border of an active tank's 32×32 box is forced to 24'h00FF00, overriding all layers except blank.
  - It is evaluated in S0 and piped alongside the other sideband.
- BBOX_DEBUG_EN undefined: no border logic and no extra registers.

Decomposition:
- Package sprite_pkg:
  - rgb_t (24-bit struct r/g/b).
  - bullet_t field offsets (VALID=0, X_LSB=9, Y_LSB=19).
  - TRANSPARENT = 24'h0.
  - BULLET_PAL constant array: tank0 = FF5500, tank1 = 00AAFF; indices above 1 cycle through these.
  - FLASH_RGB.
- Sub-module sprite_flash_timer (one per tank, via generate): counter, load, decrement and flash output.

Test Plan:
- Reset, then frame_start with tank0 at (100,100), turret ROM 24'h123456 at local (5,5). Drive DrawX=105, DrawY=105 → Red/Green/Blue = 12/34/56 exactly 3 cycles later.
- Turret and base both 0 at a tank pixel while bullet (owner 1) is valid at the same point → 00AAFF.
- Tanks 0 and 1 overlapping, both opaque → tank0 colour wins. Clear tank0_active and issue frame_start → tank1 colour.
- Change tank_x from 100 to 200 mid-frame without frame_start → pixel (105,105) unchanged. After frame_start, the tank is drawn at 200.
- hit_pulse[0] coinciding with frame_start → flash_cnt = 16. Opaque tank pixels are FFFFFF on frames where flash_cnt[1] = 1, and there are normal colours after 16 further frame_starts.
- Bullet at (2,2) with radius 4 at DrawX=0: no underflow artefacts, circle clipped correctly. blank = 0 → output 0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor: pixel struct, bullet word layout, palette.
// Pure declarations; no timing or flow-control behaviour of its own.
package sprite_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Bullet word layout: bit0 valid, [18:9] x centre, [28:19] y centre.
  typedef logic [31:0] bullet_t;
  localparam int VALID = 0;
  localparam int X_LSB = 9;
  localparam int Y_LSB = 19;

  localparam logic [23:0] TRANSPARENT = 24'h000000;
  localparam logic [23:0] FLASH_RGB   = 24'hFFFFFF;
  localparam logic [23:0] BBOX_RGB    = 24'h00FF00;
  localparam logic [23:0] BULLET_PAL [2] = '{24'hFF5500, 24'h00AAFF};

  // Owners beyond the palette size reuse its entries in turn.
  function automatic rgb_t bullet_colour(input logic [7:0] owner);
    return rgb_t'(BULLET_PAL[owner[0]]);
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel-stream, object-state and sprite-ROM bus of the compositor; master drives scan and ROM data.
// Fixed-latency stream, no backpressure: one pixel per clock.
interface sprite_compositor_if #(
  parameter int N_TANKS   = 2,
  parameter int N_BULLETS = 8,
  parameter int SPR_LOG2  = 5
);
  logic                                   frame_start;
  logic [9:0]                             DrawX;
  logic [9:0]                             DrawY;
  logic                                   blank;
  logic [N_TANKS-1:0]                     tank_active;
  logic [N_TANKS-1:0][9:0]                tank_x;
  logic [N_TANKS-1:0][9:0]                tank_y;
  logic [N_TANKS-1:0][2:0]                base_dir;
  logic [N_TANKS-1:0][2:0]                turret_dir;
  logic [N_TANKS-1:0][N_BULLETS-1:0][31:0] bullet_array;
  logic [N_TANKS-1:0]                     hit_pulse;
  logic [3+2*SPR_LOG2-1:0]                spr_addr;
  logic [2:0]                             base_dir_q;
  logic [2:0]                             turret_dir_q;
  logic [23:0]                            base_rgb;
  logic [23:0]                            turret_rgb;
  logic [2*SPR_LOG2-1:0]                  bg_addr;
  logic [23:0]                            bg_rgb;
  logic [7:0]                             Red;
  logic [7:0]                             Green;
  logic [7:0]                             Blue;

  modport master (
    output frame_start, DrawX, DrawY, blank, tank_active, tank_x, tank_y,
           base_dir, turret_dir, bullet_array, hit_pulse, base_rgb, turret_rgb, bg_rgb,
    input  spr_addr, base_dir_q, turret_dir_q, bg_addr, Red, Green, Blue
  );

  modport slave (
    input  frame_start, DrawX, DrawY, blank, tank_active, tank_x, tank_y,
           base_dir, turret_dir, bullet_array, hit_pulse, base_rgb, turret_rgb, bg_rgb,
    output spr_addr, base_dir_q, turret_dir_q, bg_addr, Red, Green, Blue
  );

endinterface

// File: rtl/sprite_flash_timer.sv
// Per-tank hit-flash frame counter: a hit reloads it, each frame_start counts it down to zero.
// Flash output is combinational from the counter; no backpressure.
module sprite_flash_timer #(
  parameter int FLASH_FRAMES = 16
) (
  input  logic CLK,
  input  logic Reset,
  input  logic hit,
  input  logic frame_start,
  output logic flash
);
  localparam int CW = $clog2(FLASH_FRAMES + 1);

  logic [CW-1:0] cnt;

  // A hit arriving on a frame boundary reloads rather than decrements.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt <= '0;
    end else if (hit) begin
      cnt <= CW'(FLASH_FRAMES);
    end else if (frame_start && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign flash = (cnt != '0) && cnt[1];

endmodule

// File: rtl/sprite_compositor.sv
// Tank/bullet/background compositor, 3-cycle fixed latency, one pixel per clock, no backpressure.
// Define BBOX_DEBUG_EN to outline every active tank's sprite box in green.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int N_TANKS      = 2,
  parameter int N_BULLETS    = 8,
  parameter int SPR_LOG2     = 5,
  parameter int BALL_SIZE    = 4,
  parameter int FLASH_FRAMES = 16
) (
  input logic                CLK,
  input logic                Reset,
  sprite_compositor_if.slave bus
);
  localparam int          IDX_W = (N_TANKS > 1) ? $clog2(N_TANKS) : 1;
  localparam int          N_BUL = N_TANKS * N_BULLETS;
  localparam int          EDGE  = 1 << SPR_LOG2;
  localparam logic [22:0] R2    = 23'(BALL_SIZE * BALL_SIZE);

  logic [N_TANKS-1:0]                      sh_active;
  logic [N_TANKS-1:0][9:0]                 sh_x;
  logic [N_TANKS-1:0][9:0]                 sh_y;
  logic [N_TANKS-1:0][2:0]                 sh_bdir;
  logic [N_TANKS-1:0][2:0]                 sh_tdir;
  logic [N_TANKS-1:0][N_BULLETS-1:0][31:0] sh_bul;

  // Object state only moves at vertical blank so a frame never tears.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      sh_active <= '0;
      sh_x      <= '0;
      sh_y      <= '0;
      sh_bdir   <= '0;
      sh_tdir   <= '0;
      sh_bul    <= '0;
    end else if (bus.frame_start) begin
      sh_active <= bus.tank_active;
      sh_x      <= bus.tank_x;
      sh_y      <= bus.tank_y;
      sh_bdir   <= bus.base_dir;
      sh_tdir   <= bus.turret_dir;
      sh_bul    <= bus.bullet_array;
    end
  end

  logic [N_TANKS-1:0]               in_box;
  logic [N_TANKS-1:0][SPR_LOG2-1:0] loc_x;
  logic [N_TANKS-1:0][SPR_LOG2-1:0] loc_y;

  for (genvar g = 0; g < N_TANKS; g++) begin : g_tank
    logic [10:0] off_x;
    logic [10:0] off_y;
    assign off_x     = {1'b0, bus.DrawX} - {1'b0, sh_x[g]};
    assign off_y     = {1'b0, bus.DrawY} - {1'b0, sh_y[g]};
    assign in_box[g] = sh_active[g]
                     && (bus.DrawX >= sh_x[g]) && (off_x < 11'(EDGE))
                     && (bus.DrawY >= sh_y[g]) && (off_y < 11'(EDGE));
    assign loc_x[g]  = off_x[SPR_LOG2-1:0];
    assign loc_y[g]  = off_y[SPR_LOG2-1:0];
  end

  logic                t_hit;
  logic [IDX_W-1:0]    t_idx;
  logic [SPR_LOG2-1:0] t_lx;
  logic [SPR_LOG2-1:0] t_ly;
  logic [2:0]          t_bdir;
  logic [2:0]          t_tdir;

  // Scanning downwards leaves the lowest-index hit as the final assignment.
  always_comb begin
    t_hit  = 1'b0;
    t_idx  = '0;
    t_lx   = '0;
    t_ly   = '0;
    t_bdir = '0;
    t_tdir = '0;
    for (int i = N_TANKS - 1; i >= 0; i--) begin
      if (in_box[i]) begin
        t_hit  = 1'b1;
        t_idx  = IDX_W'(i);
        t_lx   = loc_x[i];
        t_ly   = loc_y[i];
        t_bdir = sh_bdir[i];
        t_tdir = sh_tdir[i];
      end
    end
  end

  logic [N_BUL-1:0] bul_hit;

  for (genvar t = 0; t < N_TANKS; t++) begin : g_bt
    for (genvar s = 0; s < N_BULLETS; s++) begin : g_bs
      logic [31:0]        b;
      logic signed [21:0] dx;
      logic signed [21:0] dy;
      logic [22:0]        d2;
      logic               unused_bits;
      assign b  = sh_bul[t][s];
      assign dx = 22'(signed'({1'b0, bus.DrawX} - {1'b0, b[X_LSB +: 10]}));
      assign dy = 22'(signed'({1'b0, bus.DrawY} - {1'b0, b[Y_LSB +: 10]}));
      assign d2 = 23'(dx * dx) + 23'(dy * dy);
      assign bul_hit[t*N_BULLETS+s] = b[VALID] && (d2 <= R2);
      assign unused_bits = ^{b[31:29], b[8:1]};
    end
  end

  logic             b_hit;
  logic [IDX_W-1:0] b_own;

  always_comb begin
    b_hit = 1'b0;
    b_own = '0;
    for (int t = N_TANKS - 1; t >= 0; t--) begin
      for (int s = N_BULLETS - 1; s >= 0; s--) begin
        if (bul_hit[t*N_BULLETS+s]) begin
          b_hit = 1'b1;
          b_own = IDX_W'(t);
        end
      end
    end
  end

`ifdef BBOX_DEBUG_EN
  logic border;

  always_comb begin
    border = 1'b0;
    for (int i = 0; i < N_TANKS; i++) begin
      if (in_box[i] && (loc_x[i] == '0 || loc_x[i] == '1 || loc_y[i] == '0 || loc_y[i] == '1)) begin
        border = 1'b1;
      end
    end
  end

  logic s1_border;
  logic s2_border;
`endif

  logic                    s1_blank, s1_thit, s1_bhit;
  logic [IDX_W-1:0]        s1_tidx, s1_bown;
  logic [3+2*SPR_LOG2-1:0] spr_addr_q;
  logic [2:0]              bdir_q, tdir_q;
  logic [2*SPR_LOG2-1:0]   bg_addr_q;
  logic                    s2_blank, s2_thit, s2_bhit;
  logic [IDX_W-1:0]        s2_tidx, s2_bown;

  // Reset empties the sideband so the pipe drains as blanked pixels.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      s1_blank   <= 1'b0;
      s1_thit    <= 1'b0;
      s1_bhit    <= 1'b0;
      s1_tidx    <= '0;
      s1_bown    <= '0;
      spr_addr_q <= '0;
      bdir_q     <= '0;
      tdir_q     <= '0;
      bg_addr_q  <= '0;
      s2_blank   <= 1'b0;
      s2_thit    <= 1'b0;
      s2_bhit    <= 1'b0;
      s2_tidx    <= '0;
      s2_bown    <= '0;
`ifdef BBOX_DEBUG_EN
      s1_border  <= 1'b0;
      s2_border  <= 1'b0;
`endif
    end else begin
      s1_blank   <= bus.blank;
      s1_thit    <= t_hit;
      s1_bhit    <= b_hit;
      s1_tidx    <= t_idx;
      s1_bown    <= b_own;
      spr_addr_q <= {t_bdir, t_ly, t_lx};
      bdir_q     <= t_bdir;
      tdir_q     <= t_tdir;
      bg_addr_q  <= {bus.DrawY[SPR_LOG2-1:0], bus.DrawX[SPR_LOG2-1:0]};
      s2_blank   <= s1_blank;
      s2_thit    <= s1_thit;
      s2_bhit    <= s1_bhit;
      s2_tidx    <= s1_tidx;
      s2_bown    <= s1_bown;
`ifdef BBOX_DEBUG_EN
      s1_border  <= border;
      s2_border  <= s1_border;
`endif
    end
  end

  assign bus.spr_addr     = spr_addr_q;
  assign bus.base_dir_q   = bdir_q;
  assign bus.turret_dir_q = tdir_q;
  assign bus.bg_addr      = bg_addr_q;

  logic [N_TANKS-1:0] flash;

  for (genvar g = 0; g < N_TANKS; g++) begin : g_flash
    sprite_flash_timer #(.FLASH_FRAMES(FLASH_FRAMES)) u_timer (
      .CLK         (CLK),
      .Reset       (Reset),
      .hit         (bus.hit_pulse[g]),
      .frame_start (bus.frame_start),
      .flash       (flash[g])
    );
  end

  logic tank_flash;
  rgb_t pix;
  rgb_t out_q;

  assign tank_flash = flash[s2_tidx];

  // Sprite ROM data is only meaningful where a tank was hit, so both layers are gated.
  always_comb begin
    pix = rgb_t'(bus.bg_rgb);
    if (s2_thit && (bus.turret_rgb != TRANSPARENT)) begin
      pix = tank_flash ? rgb_t'(FLASH_RGB) : rgb_t'(bus.turret_rgb);
    end else if (s2_thit && (bus.base_rgb != TRANSPARENT)) begin
      pix = tank_flash ? rgb_t'(FLASH_RGB) : rgb_t'(bus.base_rgb);
    end else if (s2_bhit) begin
      pix = bullet_colour(8'(s2_bown));
    end
`ifdef BBOX_DEBUG_EN
    if (s2_border) begin
      pix = rgb_t'(BBOX_RGB);
    end
`endif
    if (!s2_blank) begin
      pix = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      out_q <= '0;
    end else begin
      out_q <= pix;
    end
  end

  assign bus.Red   = out_q.r;
  assign bus.Green = out_q.g;
  assign bus.Blue  = out_q.b;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with behavioural 1-cycle ROMs and hand-computed pixel colours.
module tb_sprite_compositor;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  sprite_compositor_if #(.N_TANKS(2), .N_BULLETS(8), .SPR_LOG2(5)) bus ();

  sprite_compositor #(
    .N_TANKS      (2),
    .N_BULLETS    (8),
    .SPR_LOG2     (5),
    .BALL_SIZE    (4),
    .FLASH_FRAMES (16)
  ) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] turret_mem [0:8191];
  logic [23:0] base_mem   [0:8191];
  logic [23:0] bg_mem     [0:1023];

  always @(posedge clk) begin
    bus.turret_rgb <= turret_mem[{bus.turret_dir_q, bus.spr_addr[9:0]}];
    bus.base_rgb   <= base_mem[bus.spr_addr];
    bus.bg_rgb     <= bg_mem[bus.bg_addr];
  end

  logic [23:0] rgb;
  assign rgb = {bus.Red, bus.Green, bus.Blue};

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic bl, input logic [23:0] exp);
    @(posedge clk);
    #1;
    bus.DrawX = 10'(x);
    bus.DrawY = 10'(y);
    bus.blank = bl;
    repeat (3) @(posedge clk);
    #1 check(tag, rgb, exp);
  endtask

  task automatic frame(input logic [1:0] hit);
    @(posedge clk);
    #1;
    bus.frame_start = 1'b1;
    bus.hit_pulse   = hit;
    @(posedge clk);
    #1;
    bus.frame_start = 1'b0;
    bus.hit_pulse   = '0;
  endtask

  function automatic logic [31:0] mk_bul(input int x, input int y);
    return {3'b000, 10'(y), 10'(x), 8'h00, 1'b1};
  endfunction

  localparam logic [23:0] BG = 24'h102030;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 8192; i++) begin
      turret_mem[i] = 24'h000000;
      base_mem[i]   = (i < 1024) ? 24'hAAAAAA : ((i < 2048) ? 24'hBBBBBB : 24'h000000);
    end
    for (int i = 0; i < 1024; i++) bg_mem[i] = BG;
    turret_mem[{3'd0, 5'd5, 5'd5}]   = 24'h123456;
    base_mem[{3'd0, 5'd10, 5'd10}]   = 24'h000000;
    bg_mem[{5'd3, 5'd7}]             = 24'h0F0F0F;

    rst              = 1'b1;
    bus.frame_start  = 1'b0;
    bus.DrawX        = '0;
    bus.DrawY        = '0;
    bus.blank        = 1'b0;
    bus.tank_active  = 2'b11;
    bus.tank_x       = {10'd120, 10'd100};
    bus.tank_y       = {10'd100, 10'd100};
    bus.base_dir     = {3'd1, 3'd0};
    bus.turret_dir   = {3'd1, 3'd0};
    bus.hit_pulse    = '0;
    bus.bullet_array = '0;
    bus.bullet_array[0][0] = mk_bul(300, 300);
    bus.bullet_array[1][0] = mk_bul(301, 300);
    bus.bullet_array[1][3] = mk_bul(110, 110);
    bus.bullet_array[1][5] = mk_bul(2, 2);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_rgb", rgb, 24'h000000);
    check("reset_bg_addr", 24'(bus.bg_addr), 24'h000000);

    // Shadow state is empty until the first frame_start.
    pix("pre_frame_tank",   105, 105, 1'b1, BG);
    pix("pre_frame_bullet", 300, 300, 1'b1, BG);

    frame(2'b00);
    pix("blank_forces_zero", 0, 0, 1'b0, 24'h000000);
    @(posedge clk);
    #1;
    bus.DrawX = 10'd105;
    bus.DrawY = 10'd105;
    bus.blank = 1'b1;
    repeat (2) @(posedge clk);
    #1 check("latency_not_before_3", rgb, 24'h000000);
    @(posedge clk);
    #1 check("turret_at_3", rgb, 24'h123456);

    pix("bullet_under_tank",  110, 110, 1'b1, 24'h00AAFF);
    pix("tank_over_bullet",   112, 110, 1'b1, 24'hAAAAAA);
    pix("overlap_tank0_wins", 125, 105, 1'b1, 24'hAAAAAA);
    pix("tank0_right_edge",   131, 105, 1'b1, 24'hAAAAAA);
    pix("tank1_past_tank0",   132, 105, 1'b1, 24'hBBBBBB);
    pix("left_of_tank",        99, 105, 1'b1, BG);
    pix("below_tank",         105, 132, 1'b1, BG);
    pix("bullet_lowest_flat", 300, 300, 1'b1, 24'hFF5500);
    pix("bullet_radius_edge", 304, 300, 1'b1, 24'hFF5500);
    pix("bullet_fallthrough", 303, 303, 1'b1, 24'h00AAFF);
    pix("bullet_miss",        305, 303, 1'b1, BG);
    pix("bullet_corner_x0",     0,   0, 1'b1, 24'h00AAFF);
    pix("bullet_edge_x6",       6,   2, 1'b1, 24'h00AAFF);
    pix("bullet_clip_x7",       7,   2, 1'b1, BG);
    pix("bullet_clip_y6",       0,   6, 1'b1, BG);
    pix("bullet_no_wrap",    1023,   2, 1'b1, BG);
    pix("bg_addr_mod32",       39,  35, 1'b1, 24'h0F0F0F);

    bus.tank_active = 2'b10;
    frame(2'b00);
    pix("tank1_after_clear", 125, 105, 1'b1, 24'hBBBBBB);
    pix("tank0_gone",        105, 105, 1'b1, BG);

    bus.tank_active = 2'b11;
    frame(2'b00);
    bus.tank_x[0] = 10'd200;
    pix("no_tear_mid_frame", 105, 105, 1'b1, 24'h123456);
    frame(2'b00);
    pix("moved_old_spot",    105, 105, 1'b1, BG);
    pix("moved_new_spot",    205, 105, 1'b1, 24'h123456);

    // Hit coincides with frame_start: counter loads 16, no flash since bit1 = 0.
    frame(2'b01);
    pix("flash_load16", 205, 105, 1'b1, 24'h123456);
    for (int f = 1; f <= 17; f++) begin
      frame(2'b00);
      cnt = (16 - f > 0) ? 16 - f : 0;
      pix($sformatf("flash_f%0d", f), 205, 105, 1'b1,
          ((cnt != 0) && cnt[1]) ? 24'hFFFFFF : 24'h123456);
      if (f == 1) begin
        pix("flash_base",        212, 110, 1'b1, 24'hFFFFFF);
        pix("flash_transparent", 210, 110, 1'b1, BG);
        pix("flash_other_tank",  125, 105, 1'b1, 24'hBBBBBB);
      end
    end

    // Mid-line reset drains the pipe as three zero pixels.
    pix("pre_reset", 205, 105, 1'b1, 24'h123456);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("reset_flush_0", rgb, 24'h000000);
    @(posedge clk);
    #1 check("reset_flush_1", rgb, 24'h000000);
    @(posedge clk);
    #1 check("reset_flush_2", rgb, 24'h000000);
    @(posedge clk);
    #1 check("reset_after_flush", rgb, BG);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
